// File: rtl/proc_run_controller_pkg.sv
// Shared types and defaults for the processor run controller.
//   state_e  : run sequencer states
//   status_t : end-of-run status flags
package proc_ctrl_pkg;

    localparam int unsigned DEF_RESET_CYCLES = 2;
    localparam int unsigned DEF_MAX_CYCLES   = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic done;
        logic pass;
        logic timeout;
    } status_t;

endpackage

// File: rtl/proc_run_controller_if.sv
// Host and core facing signals of the run controller.
//   master : host/core side (drives run requests and core observations)
//   slave  : controller side (drives core reset/start PC and run status)
interface proc_run_controller_if #(
    parameter int unsigned PC_W   = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned WDOG_W = 16
);
    logic              start;
    logic              abort;
    logic [PC_W-1:0]   start_pc;
    logic [PC_W-1:0]   end_pc;
    logic [DATA_W-1:0] expected;
    logic [PC_W-1:0]   currentpc;
    logic [DATA_W-1:0] MemtoRegOut;
    logic              proc_resetl;
    logic [PC_W-1:0]   proc_startpc;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [DATA_W-1:0] result;
    logic [WDOG_W-1:0] cycles;

    modport master (
        output start, abort, start_pc, end_pc, expected, currentpc, MemtoRegOut,
        input  proc_resetl, proc_startpc, busy, done, pass, timeout, result, cycles
    );

    modport slave (
        input  start, abort, start_pc, end_pc, expected, currentpc, MemtoRegOut,
        output proc_resetl, proc_startpc, busy, done, pass, timeout, result, cycles
    );
endinterface

// File: rtl/proc_run_controller_watchdog.sv
// Saturating cycle counter with clear and enable.
//   CLK, resetl   : clock, synchronous active-low reset
//   clr_i         : zero the count (wins over en_i)
//   en_i          : count this cycle
//   count_o       : registered count
//   expired_c_o   : high in the enabled cycle whose edge brings the count to MAX
module run_watchdog #(
    parameter int unsigned W   = 16,
    parameter int unsigned MAX = 255
) (
    input  logic         CLK,
    input  logic         resetl,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         expired_c_o
);
    localparam logic [W-1:0] MAX_W = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    // Look-ahead so the owner can act on the same edge the count lands on MAX.
    assign expired_c_o = en_i && !clr_i && (count_d == MAX_W);

endmodule

// File: rtl/proc_run_controller.sv
// Run sequencer for the singlecycle core: holds the core in reset, releases
// it, waits for currentpc to reach end_pc, then captures and checks the
// write-back value. A watchdog ends runaway programs.
//   CLK, resetl : clock, synchronous active-low reset
//   bus (slave) : start/abort/start_pc/end_pc/expected and core currentpc,
//                 MemtoRegOut in; proc_resetl, proc_startpc, busy, done,
//                 pass, timeout, result, cycles out (all registered)
module proc_run_controller
    import proc_ctrl_pkg::*;
#(
    parameter int unsigned PC_W         = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned WDOG_W       = 16,
    parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES
) (
    input  logic                  CLK,
    input  logic                  resetl,
    proc_run_controller_if.slave  bus
);
    state_e            state_q, state_d;
    logic [PC_W-1:0]   startpc_q, startpc_d;
    logic [PC_W-1:0]   endpc_q, endpc_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic [DATA_W-1:0] result_q, result_d;
    status_t           status_q, status_d;
    logic              proc_resetl_q, proc_resetl_d;
    logic              busy_q, busy_d;

    logic              start_acc;
    logic              hold_exp;
    logic              run_exp;
    logic [WDOG_W-1:0] run_count;
    logic [WDOG_W-1:0] hold_count_unused;

    // Counts RESET cycles; expires on the last hold cycle.
    run_watchdog #(.W(WDOG_W), .MAX(RESET_CYCLES)) u_hold (
        .CLK         (CLK),
        .resetl      (resetl),
        .clr_i       (start_acc),
        .en_i        (state_q == ST_RESET),
        .count_o     (hold_count_unused),
        .expired_c_o (hold_exp)
    );

    // Counts RUN cycles; its count is the visible cycles output.
    run_watchdog #(.W(WDOG_W), .MAX(MAX_CYCLES)) u_wdog (
        .CLK         (CLK),
        .resetl      (resetl),
        .clr_i       (start_acc),
        .en_i        (state_q == ST_RUN),
        .count_o     (run_count),
        .expired_c_o (run_exp)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        startpc_d     = startpc_q;
        endpc_d       = endpc_q;
        expected_d    = expected_q;
        result_d      = result_q;
        status_d      = status_q;
        proc_resetl_d = proc_resetl_q;
        start_acc     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_IDLE) begin
                    proc_resetl_d = 1'b0;
                end
                // Start beats abort in DONE since abort is ignored here.
                if (bus.start) begin
                    start_acc     = 1'b1;
                    startpc_d     = bus.start_pc;
                    endpc_d       = bus.end_pc;
                    expected_d    = bus.expected;
                    status_d      = '0;
                    proc_resetl_d = 1'b0;
                    state_d       = ST_RESET;
                end
            end
            ST_RESET, ST_RUN: begin
                if (bus.abort) begin
                    status_d.done    = 1'b1;
                    status_d.pass    = 1'b0;
                    status_d.timeout = 1'b0;
                    proc_resetl_d    = 1'b0;
                    state_d          = ST_DONE;
                end else if (state_q == ST_RESET) begin
                    if (hold_exp) begin
                        proc_resetl_d = 1'b1;
                        state_d       = ST_RUN;
                    end
                end else if (bus.currentpc >= endpc_q) begin
                    // End reached takes priority over a coincident timeout.
                    result_d         = bus.MemtoRegOut;
                    status_d.done    = 1'b1;
                    status_d.pass    = (bus.MemtoRegOut == expected_q);
                    status_d.timeout = 1'b0;
                    state_d          = ST_DONE;
                end else if (run_exp) begin
                    result_d         = bus.MemtoRegOut;
                    status_d.done    = 1'b1;
                    status_d.pass    = 1'b0;
                    status_d.timeout = 1'b1;
                    state_d          = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RESET) || (state_d == ST_RUN);
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_q       <= ST_IDLE;
            startpc_q     <= '0;
            endpc_q       <= '0;
            expected_q    <= '0;
            result_q      <= '0;
            status_q      <= '0;
            proc_resetl_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            startpc_q     <= startpc_d;
            endpc_q       <= endpc_d;
            expected_q    <= expected_d;
            result_q      <= result_d;
            status_q      <= status_d;
            proc_resetl_q <= proc_resetl_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.proc_resetl  = proc_resetl_q;
    assign bus.proc_startpc = startpc_q;
    assign bus.busy         = busy_q;
    assign bus.done         = status_q.done;
    assign bus.pass         = status_q.pass;
    assign bus.timeout      = status_q.timeout;
    assign bus.result       = result_q;
    assign bus.cycles       = run_count;

endmodule

// File: tb/tb_proc_run_controller.sv
// Scoreboard bench for proc_run_controller with a stub PC += 4 core.
module tb_proc_run_controller;
    localparam int unsigned MAX_CYC = 255;

    logic clk = 1'b0;
    logic resetl;
    always #5 clk = ~clk;

    proc_run_controller_if #(.PC_W(64), .DATA_W(64), .WDOG_W(16)) bus ();

    proc_run_controller #(
        .PC_W(64), .DATA_W(64), .RESET_CYCLES(2), .WDOG_W(16), .MAX_CYCLES(MAX_CYC)
    ) dut (
        .CLK    (clk),
        .resetl (resetl),
        .bus    (bus)
    );

    // Stub core: loads proc_startpc while held in reset, else steps by 4.
    logic [63:0] pc = 64'd0;
    logic        stuck = 1'b0;
    logic [63:0] stuck_pc = 64'd0;
    logic [63:0] ret_pc = '1;
    logic [63:0] ret_val = 64'd0;

    always @(posedge clk) begin
        if (!bus.proc_resetl) pc <= bus.proc_startpc;
        else                  pc <= pc + 64'd4;
    end
    assign bus.currentpc   = stuck ? stuck_pc : pc;
    assign bus.MemtoRegOut = (bus.currentpc == ret_pc) ? ret_val : ~bus.currentpc;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [63:0] result;
        logic [63:0] startpc;
        int          cycles;
        bit          chk_cycles;
        bit          aborted;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] last_result = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [63:0] p);
        return (p == ret_pc) ? ret_val : ~p;
    endfunction

    // Reference: walk the core's PC sequence cycle by cycle through the run rules.
    function automatic exp_t model_run(input logic [63:0] spc, input logic [63:0] epc,
                                       input logic [63:0] expv, input bit stk,
                                       input logic [63:0] stkpc, input int abort_at);
        exp_t        e;
        logic [63:0] p;
        e.startpc = spc; e.pass = 1'b0; e.timeout = 1'b0; e.result = last_result;
        e.cycles = 0; e.chk_cycles = 1'b0; e.aborted = 1'b0;
        for (int c = 1; c <= int'(MAX_CYC); c++) begin
            p = stk ? stkpc : spc + 64'(4 * (c - 1));
            if (c == abort_at) begin
                e.aborted = 1'b1;
                return e;
            end
            if (p >= epc) begin
                e.result = data_of(p); e.pass = (e.result == expv);
                e.cycles = c; e.chk_cycles = 1'b1;
                return e;
            end
            if (c == int'(MAX_CYC)) begin
                e.result = data_of(p); e.timeout = 1'b1;
                e.cycles = c; e.chk_cycles = 1'b1;
            end
        end
        return e;
    endfunction

    // Monitor: every rising done retires one scoreboard entry.
    logic prev_done = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetl && bus.done && !prev_done) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pass", 64'(bus.pass), 64'(e.pass));
                    chk("timeout", 64'(bus.timeout), 64'(e.timeout));
                    chk("result", bus.result, e.result);
                    chk("proc_startpc", bus.proc_startpc, e.startpc);
                    chk("busy_at_done", 64'(bus.busy), 64'd0);
                    if (e.chk_cycles) chk("cycles", 64'(bus.cycles), 64'(e.cycles));
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_proc_resetl"}, 64'(bus.proc_resetl), 64'd0);
        chk({tag, "_proc_startpc"}, bus.proc_startpc, 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_pass"}, 64'(bus.pass), 64'd0);
        chk({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
        chk({tag, "_result"}, bus.result, 64'd0);
        chk({tag, "_cycles"}, 64'(bus.cycles), 64'd0);
    endtask

    // One run, started at a negedge with the DUT in IDLE or DONE.
    task automatic do_run(input logic [63:0] spc, input logic [63:0] epc, input logic [63:0] expv,
                          input bit stk, input logic [63:0] stkpc,
                          input logic [63:0] rpc, input logic [63:0] rval,
                          input int abort_at, input int busy_start_at);
        exp_t e;
        int   last;
        int   waited;
        ret_pc = rpc; ret_val = rval; stuck = stk; stuck_pc = stkpc;
        e = model_run(spc, epc, expv, stk, stkpc, abort_at);
        last_result = e.result;
        sb.push_back(e);
        bus.start = 1'b1; bus.start_pc = spc; bus.end_pc = epc; bus.expected = expv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.start_pc = {$urandom, $urandom}; bus.end_pc = {$urandom, $urandom};
        bus.expected = {$urandom, $urandom};
        chk("hold_cycle1", 64'(bus.proc_resetl), 64'd0);
        chk("busy_in_reset", 64'(bus.busy), 64'd1);
        chk("done_cleared", 64'(bus.done), 64'd0);
        @(negedge clk);
        chk("hold_cycle2", 64'(bus.proc_resetl), 64'd0);
        @(negedge clk);
        chk("release", 64'(bus.proc_resetl), 64'd1);
        last = (abort_at > busy_start_at) ? abort_at : busy_start_at;
        if (last > 0) begin
            for (int c = 1; c <= last; c++) begin
                if (c > 1) @(negedge clk);
                bus.start = (c == busy_start_at);
                bus.abort = (c == abort_at);
                if (c == busy_start_at) bus.start_pc = spc ^ 64'hABC0;
            end
            @(negedge clk);
            bus.start = 1'b0; bus.abort = 1'b0;
        end
        waited = 0;
        while (!bus.done && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.done) chk("done_wait_timeout", 64'(bus.done), 64'd1);
        @(negedge clk);
        chk("proc_resetl_in_done", 64'(bus.proc_resetl), e.aborted ? 64'd0 : 64'd1);
    endtask

    initial begin
        logic [63:0] spc, epc, rpc, rval, expv, stkpc;
        int          steps, mode, ab, bs;
        bit          stk;

        resetl = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.start_pc = '0; bus.end_pc = '0; bus.expected = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        resetl = 1'b1;
        @(negedge clk);
        chk("idle_proc_resetl", 64'(bus.proc_resetl), 64'd0);

        // Directed runs from the plan.
        do_run(64'h0, 64'h30, 64'hF, 1'b0, 64'h0, 64'h30, 64'hF, 0, 0);
        chk("normal_cycles13", 64'(bus.cycles), 64'd13);
        do_run(64'h30, 64'h54, 64'h1234_5678_9abc_def0, 1'b0, 64'h0,
               64'h54, 64'h1234_5678_9abc_def0, 0, 0);
        chk("b2b_cycles10", 64'(bus.cycles), 64'd10);
        do_run(64'h0, 64'h30, 64'hF, 1'b0, 64'h0, 64'h30, 64'hE, 0, 0);
        chk("mismatch_result", bus.result, 64'hE);
        do_run(64'h0, 64'h30, 64'h77, 1'b1, 64'h8, 64'h8, 64'h55, 0, 0);
        chk("wdog_cycles255", 64'(bus.cycles), 64'd255);
        do_run(64'h200, 64'h300, 64'h1, 1'b0, 64'h0, 64'h300, 64'h1, 5, 2);
        do_run(64'h40, 64'h10, 64'hAA, 1'b0, 64'h0, 64'h40, 64'hAA, 0, 0);

        // Randomized runs.
        for (int r = 0; r < 24; r++) begin
            spc   = 64'($urandom_range(0, 1023)) << 2;
            steps = $urandom_range(0, 30);
            mode  = $urandom_range(0, 9);
            stk   = (mode == 1);
            epc   = spc + 64'(4 * steps);
            stkpc = spc;
            if (mode == 0) epc = spc >> 1;
            if (stk) epc = spc + 64'(4 * (steps + 1));
            rpc   = stk ? stkpc : ((epc <= spc) ? spc : epc);
            rval  = {$urandom, $urandom};
            expv  = ($urandom_range(0, 1) == 1) ? rval : rval ^ 64'd1;
            ab    = (mode == 2 && steps >= 3) ? $urandom_range(1, steps) : 0;
            bs    = 0;
            if (!stk && steps >= 2 && $urandom_range(0, 1) == 1) begin
                if (ab == 0)     bs = $urandom_range(1, steps);
                else if (ab > 1) bs = $urandom_range(1, ab - 1);
            end
            do_run(spc, epc, expv, stk, stkpc, rpc, rval, ab, bs);
        end

        // Reset in the middle of a run discards it.
        ret_pc = 64'h1000; stuck = 1'b0;
        bus.start = 1'b1; bus.start_pc = 64'h100; bus.end_pc = 64'h1000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrun_busy", 64'(bus.busy), 64'd1);
        resetl = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrun_rst");
        resetl = 1'b1;
        last_result = 64'd0;
        repeat (3) @(negedge clk);
        chk("after_rst_idle_busy", 64'(bus.busy), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
